axis_hdr_insert_strip: RTL and testbench
========================================

Name: axis_hdr_insert_strip

Overview:
Per-packet AXI-Stream byte re-aligner and the parametrised successor of the fixed header inserter. A command beat selects one of two modes for the next packet:
- INSERT: prepend 0..N header bytes.
- STRIP: drop 0..N-1 leading payload bytes.

The remaining bytes are re-packed into full beats with byte-granular keep, including the extra trailing beat or the merged last beat. It sits between the packet source and the framing/MAC stage, on the same clock.

Parameters:
DATA_WD, 32, stream data width in bits (multiple of 8, ≥16)
DATA_BYTE_WD, DATA_WD/8, bytes per beat (N)
BYTE_CNT_WD, $clog2(DATA_BYTE_WD)+1, width of byte count (holds 0..N)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_cmd  in  1  command valid
ready_cmd  out  1  command ready
cmd_mode  in  1  0=INSERT, 1=STRIP
data_insert  in  DATA_WD  header; valid bytes are the low cmd_byte_cnt lanes
cmd_byte_cnt  in  BYTE_CNT_WD  bytes to insert or strip
valid_in  in  1  payload valid
data_in  in  DATA_WD  payload; MSB lane = first byte
keep_in  in  DATA_BYTE_WD  payload keep; all-ones except last beat (MSB-aligned contiguous)
last_in  in  1  payload last
ready_in  out  1  payload ready
valid_out  out  1  output valid
data_out  out  DATA_WD  output data; invalid lanes driven 0
keep_out  out  DATA_BYTE_WD  output keep; MSB-aligned contiguous
last_out  out  1  output last
ready_out  in  1  output ready

Behaviour:
- Reset (async assert, sync release): state=IDLE. ready_cmd=1, ready_in=0, valid_out=0, data_out=0, keep_out=0, last_out=0. Residual buffer cleared.
- Handshakes: a transfer occurs when valid&ready at posedge clk. While valid_out=1 and ready_out=0, data_out, keep_out and last_out hold stable. ready_in is deasserted whenever the output register holds an un-taken beat that cannot be refilled in that cycle. Inputs are never dropped.
- Commands:
  - A command is accepted only in IDLE (ready_cmd=1 only in IDLE).
  - INSERT with cnt=0 is a passthrough.
  - INSERT with cnt>N saturates to N.
  - STRIP with cnt≥N saturates to N-1.
- States:
  - IDLE: on cmd handshake, latch mode/cnt/header → STREAM. In INSERT mode the header bytes preload the residual buffer (2*DATA_WD wide, residual count R=cnt).
  - STREAM:
    - ready_in asserted subject to back-pressure.
    - Each accepted beat appends its valid bytes to the residual.
    - When R≥N, emit the top N bytes with keep all-ones.
    - In STRIP mode, the first accepted beat discards its top s bytes before appending.
    - On an accepted last_in:
      - if remaining R≤N, emit one final beat with last_out=1 and keep showing R MSB lanes → IDLE;
      - else → FLUSH.
    - In STRIP mode, a beat is not emitted until the next beat, or last, is known. This lets a short last beat merge into the previous output beat.
  - FLUSH: ready_in=0. Emit the residual (R<N bytes) with last_out=1 → IDLE on the output handshake.
- Latency: first output beat is valid one cycle after the enabling input handshake. Output is registered. Sustained throughput is 1 beat/cycle with ready_out=1, excluding the FLUSH beat and the command cycle.
- Boundary conditions:
  - INSERT cnt=N: header is a full beat, data is unshifted, no FLUSH.
  - Single-beat STRIP packet with k≤s valid bytes: emit one beat with keep_out=0 and last_out=1 to preserve the packet boundary.
  - Total output bytes always equal payload+cnt (INSERT) or max(payload−s, 0) (STRIP).
  - Simultaneous output take and input accept in the same cycle must not stall.
  - rst_n asserted mid-packet: everything is discarded immediately and the next packet starts from IDLE.

Decomposition:
- Package axis_realign_pkg holds:
  - mode encodings MODE_INSERT/MODE_STRIP;
  - the state enum IDLE/STREAM/FLUSH;
  - functions keep_from_cnt (count → MSB-aligned keep) and cnt_from_keep (popcount of contiguous keep).
- One sub-module is natural: axis_skid_reg, the registered output stage with skid buffer that holds output under back-pressure.

Test Plan:
1. N=4, INSERT cnt=2, hdr=0x0000AABB; payload 0x11223344, 0x55667788, 0x99AABBCC (keep 1111, last) → out 0xAABB1122, 0x33445566, 0x778899AA (keep 1111); then FLUSH beat 0xBBCC0000 with keep 1100 and last.
2. INSERT cnt=4, hdr=0xDEADBEEF; payload 0x12345678 keep 1110 last → 0xDEADBEEF keep 1111; then 0x12345600 keep 1110 last.
3. STRIP cnt=1; payload 0x11223344, 0x55660000 keep 1100 last → 0x22334455 keep 1111; then 0x66000000 keep 1000 last.
4. STRIP cnt=3; payload 0x11223344, 0x55000000 keep 1000 last → single merged beat 0x44550000 keep 1100 last. Also single beat 0x11000000 keep 1000 → keep 0000 last.
5. Scenario 1 repeated with ready_out pattern 1,0,0,1,0,1… and random valid_in gaps → identical output sequence; outputs stable on every stall cycle.
6. rst_n pulsed low during beat 2 of scenario 1 → outputs 0 in the same cycle; ready_cmd=1 after release; a following INSERT cnt=0 packet passes through unchanged.

Source files
------------

// File: rtl/axis_realign_pkg.sv
// Shared encodings and keep/count helpers for the AXI-Stream byte re-aligner.
// Keep vectors are MSB-aligned: lane N-1 carries the first byte of a beat.
package axis_realign_pkg;

  localparam logic MODE_INSERT = 1'b0;
  localparam logic MODE_STRIP  = 1'b1;

  // Widest keep vector the helpers handle (1024-bit data).
  localparam int KEEP_MAX = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  function automatic logic [KEEP_MAX-1:0] keep_from_cnt(input int cnt, input int nbytes);
    logic [KEEP_MAX-1:0] k;
    k = {KEEP_MAX{1'b0}};
    for (int i = 0; i < KEEP_MAX; i++) begin
      if ((i < nbytes) && ((i + cnt) >= nbytes)) begin
        k[i] = 1'b1;
      end
    end
    return k;
  endfunction

  function automatic int cnt_from_keep(input logic [KEEP_MAX-1:0] keep);
    int c;
    c = 0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      if (keep[i]) begin
        c = c + 32'sd1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Registered output stage with a one-entry skid buffer; upstream ready is a
// pure register decode so it never depends combinationally on o_ready's partner.
module axis_skid_reg #(
  parameter int DATA_WD = 32,
  parameter int KEEP_WD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_WD-1:0] i_data,
  input  logic [KEEP_WD-1:0] i_keep,
  input  logic               i_last,
  output logic               o_valid,
  output logic [DATA_WD-1:0] o_data,
  output logic [KEEP_WD-1:0] o_keep,
  output logic               o_last,
  input  logic               i_ready
);

  logic               r_valid;
  logic [DATA_WD-1:0] r_data;
  logic [KEEP_WD-1:0] r_keep;
  logic               r_last;
  logic               r_sk_valid;
  logic [DATA_WD-1:0] r_sk_data;
  logic [KEEP_WD-1:0] r_sk_keep;
  logic               r_sk_last;

  assign o_ready = ~r_sk_valid;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_last  = r_last;

  // Output register refills from skid first, then from upstream; skid catches a beat during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_data     <= {DATA_WD{1'b0}};
      r_keep     <= {KEEP_WD{1'b0}};
      r_last     <= 1'b0;
      r_sk_valid <= 1'b0;
      r_sk_data  <= {DATA_WD{1'b0}};
      r_sk_keep  <= {KEEP_WD{1'b0}};
      r_sk_last  <= 1'b0;
    end else if (!r_valid || i_ready) begin
      if (r_sk_valid) begin
        r_valid    <= 1'b1;
        r_data     <= r_sk_data;
        r_keep     <= r_sk_keep;
        r_last     <= r_sk_last;
        r_sk_valid <= 1'b0;
        r_sk_data  <= {DATA_WD{1'b0}};
        r_sk_keep  <= {KEEP_WD{1'b0}};
        r_sk_last  <= 1'b0;
      end else if (i_valid) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
        r_keep  <= i_keep;
        r_last  <= i_last;
      end else begin
        r_valid <= 1'b0;
        r_data  <= {DATA_WD{1'b0}};
        r_keep  <= {KEEP_WD{1'b0}};
        r_last  <= 1'b0;
      end
    end else if (i_valid && !r_sk_valid) begin
      r_sk_valid <= 1'b1;
      r_sk_data  <= i_data;
      r_sk_keep  <= i_keep;
      r_sk_last  <= i_last;
    end else begin
      r_sk_valid <= r_sk_valid;
    end
  end

endmodule

// File: rtl/axis_hdr_insert_strip.sv
// Per-packet AXI-Stream re-aligner: prepends header bytes or strips leading
// payload bytes, re-packing the rest into full MSB-first beats.
module axis_hdr_insert_strip
  import axis_realign_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_cmd,
  output logic                    ready_cmd,
  input  logic                    cmd_mode,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [BYTE_CNT_WD-1:0]  cmd_byte_cnt,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  localparam int TW = BYTE_CNT_WD + 1;
  localparam logic [BYTE_CNT_WD-1:0] N_C  = BYTE_CNT_WD'(DATA_BYTE_WD);
  localparam logic [BYTE_CNT_WD-1:0] N_M1 = BYTE_CNT_WD'(DATA_BYTE_WD - 1);
  localparam logic [TW-1:0]          N_T  = TW'(DATA_BYTE_WD);

  state_e                   r_state;
  logic                     r_mode;
  logic                     r_first;
  logic [BYTE_CNT_WD-1:0]   r_strip;
  logic [BYTE_CNT_WD-1:0]   r_cnt;
  logic [2*DATA_WD-1:0]     r_res;

  state_e                   w_state_nxt;
  logic                     w_mode_nxt;
  logic                     w_first_nxt;
  logic [BYTE_CNT_WD-1:0]   w_strip_nxt;
  logic [BYTE_CNT_WD-1:0]   w_cnt_nxt;
  logic [2*DATA_WD-1:0]     w_res_nxt;
  logic                     w_push_valid;
  logic [DATA_WD-1:0]       w_push_data;
  logic [DATA_BYTE_WD-1:0]  w_push_keep;
  logic                     w_push_last;
  logic                     w_skid_ready;
  logic                     w_ready_in;
  logic                     w_ready_cmd;
  logic [BYTE_CNT_WD-1:0]   w_cmd_cnt;
  logic [DATA_WD-1:0]       w_hdr_shift;
  logic [DATA_WD-1:0]       w_byte_mask;
  logic [DATA_WD-1:0]       w_in_shift;
  logic [2*DATA_WD-1:0]     w_cat;
  logic [TW-1:0]            w_k_in;
  logic [TW-1:0]            w_k_eff;
  logic [TW-1:0]            w_strip_now;
  logic [TW-1:0]            w_total;

  assign ready_cmd = w_ready_cmd;
  assign ready_in  = w_ready_in;

  // Expand byte keep into a bit mask so invalid input lanes never reach the residual.
  always_comb begin
    w_byte_mask = {DATA_WD{1'b0}};
    for (int b = 0; b < DATA_BYTE_WD; b++) begin
      w_byte_mask[b*8 +: 8] = {8{keep_in[b]}};
    end
  end

  // Saturate the command count for the selected mode.
  always_comb begin
    w_cmd_cnt = cmd_byte_cnt;
    if (cmd_mode == MODE_INSERT) begin
      if (cmd_byte_cnt > N_C) w_cmd_cnt = N_C;
      else                    w_cmd_cnt = cmd_byte_cnt;
    end else begin
      if (cmd_byte_cnt >= N_C) w_cmd_cnt = N_M1;
      else                     w_cmd_cnt = cmd_byte_cnt;
    end
  end

  // Header bytes sit in the low lanes; shifting left puts the first one at the MSB.
  assign w_hdr_shift = data_insert << {(N_C - w_cmd_cnt), 3'b000};
  assign w_k_in      = TW'(cnt_from_keep(KEEP_MAX'(keep_in)));
  assign w_strip_now = ((r_mode == MODE_STRIP) && r_first) ? TW'(r_strip) : {TW{1'b0}};
  assign w_k_eff     = (w_k_in > w_strip_now) ? (w_k_in - w_strip_now) : {TW{1'b0}};
  assign w_in_shift  = (data_in & w_byte_mask) << {w_strip_now, 3'b000};
  assign w_cat       = r_res | ({w_in_shift, {DATA_WD{1'b0}}} >> {r_cnt, 3'b000});
  assign w_total     = TW'(r_cnt) + w_k_eff;

  // Next-state, residual update and beat hand-off to the output stage.
  always_comb begin
    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode;
    w_first_nxt  = r_first;
    w_strip_nxt  = r_strip;
    w_cnt_nxt    = r_cnt;
    w_res_nxt    = r_res;
    w_push_valid = 1'b0;
    w_push_data  = {DATA_WD{1'b0}};
    w_push_keep  = {DATA_BYTE_WD{1'b0}};
    w_push_last  = 1'b0;
    w_ready_in   = 1'b0;
    w_ready_cmd  = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready_cmd = 1'b1;
        if (valid_cmd) begin
          w_state_nxt = STREAM;
          w_mode_nxt  = cmd_mode;
          w_first_nxt = 1'b1;
          if (cmd_mode == MODE_INSERT) begin
            w_res_nxt   = {w_hdr_shift, {DATA_WD{1'b0}}};
            w_cnt_nxt   = w_cmd_cnt;
            w_strip_nxt = {BYTE_CNT_WD{1'b0}};
          end else begin
            w_res_nxt   = {2*DATA_WD{1'b0}};
            w_cnt_nxt   = {BYTE_CNT_WD{1'b0}};
            w_strip_nxt = w_cmd_cnt;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      STREAM: begin
        if (r_cnt == N_C) begin
          // A full-beat header goes out on its own before any payload is taken.
          w_push_valid = 1'b1;
          w_push_data  = r_res[2*DATA_WD-1:DATA_WD];
          w_push_keep  = {DATA_BYTE_WD{1'b1}};
          if (w_skid_ready) begin
            w_res_nxt = {r_res[DATA_WD-1:0], {DATA_WD{1'b0}}};
            w_cnt_nxt = {BYTE_CNT_WD{1'b0}};
          end else begin
            w_res_nxt = r_res;
          end
        end else begin
          w_ready_in = w_skid_ready;
          if (valid_in && w_skid_ready) begin
            w_first_nxt = 1'b0;
            w_push_data = w_cat[2*DATA_WD-1:DATA_WD];
            if (last_in && (w_total <= N_T)) begin
              w_push_valid = 1'b1;
              w_push_keep  = DATA_BYTE_WD'(keep_from_cnt(int'(w_total), DATA_BYTE_WD));
              w_push_last  = 1'b1;
              w_res_nxt    = {2*DATA_WD{1'b0}};
              w_cnt_nxt    = {BYTE_CNT_WD{1'b0}};
              w_state_nxt  = IDLE;
            end else if (w_total >= N_T) begin
              w_push_valid = 1'b1;
              w_push_keep  = {DATA_BYTE_WD{1'b1}};
              w_res_nxt    = {w_cat[DATA_WD-1:0], {DATA_WD{1'b0}}};
              w_cnt_nxt    = BYTE_CNT_WD'(w_total - N_T);
              if (last_in) w_state_nxt = FLUSH;
              else         w_state_nxt = STREAM;
            end else begin
              w_res_nxt = w_cat;
              w_cnt_nxt = BYTE_CNT_WD'(w_total);
            end
          end else begin
            w_res_nxt = r_res;
          end
        end
      end
      FLUSH: begin
        w_push_valid = 1'b1;
        w_push_data  = r_res[2*DATA_WD-1:DATA_WD];
        w_push_keep  = DATA_BYTE_WD'(keep_from_cnt(int'(r_cnt), DATA_BYTE_WD));
        w_push_last  = 1'b1;
        if (w_skid_ready) begin
          w_res_nxt   = {2*DATA_WD{1'b0}};
          w_cnt_nxt   = {BYTE_CNT_WD{1'b0}};
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = FLUSH;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Packet state and residual byte buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mode  <= MODE_INSERT;
      r_first <= 1'b0;
      r_strip <= {BYTE_CNT_WD{1'b0}};
      r_cnt   <= {BYTE_CNT_WD{1'b0}};
      r_res   <= {2*DATA_WD{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_first <= w_first_nxt;
      r_strip <= w_strip_nxt;
      r_cnt   <= w_cnt_nxt;
      r_res   <= w_res_nxt;
    end
  end

  axis_skid_reg #(
    .DATA_WD (DATA_WD),
    .KEEP_WD (DATA_BYTE_WD)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_push_valid),
    .o_ready (w_skid_ready),
    .i_data  (w_push_data),
    .i_keep  (w_push_keep),
    .i_last  (w_push_last),
    .o_valid (valid_out),
    .o_data  (data_out),
    .o_keep  (keep_out),
    .o_last  (last_out),
    .i_ready (ready_out)
  );

endmodule

// File: tb/tb_axis_hdr_insert_strip.sv
// Bench for axis_hdr_insert_strip: directed packets with literal expectations
// plus randomized packets checked against a byte-queue reference model.
module tb_axis_hdr_insert_strip;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_cmd = 1'b0;
  logic        ready_cmd;
  logic        cmd_mode = 1'b0;
  logic [31:0] data_insert = 32'h0;
  logic [2:0]  cmd_byte_cnt = 3'd0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic [3:0]  keep_in = 4'h0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;

  int n_pass = 0;
  int n_total = 0;
  int rdy_mode = 0;
  int gap_max = 0;
  int stall_total = 0;
  bit chk_stable = 1'b0;

  logic [31:0] pay_d[$];
  logic [3:0]  pay_k[$];
  logic [31:0] exp_d[$];
  logic [3:0]  exp_k[$];
  logic        exp_l[$];
  logic [31:0] got_d[$];
  logic [3:0]  got_k[$];
  logic        got_l[$];

  always #5 clk = ~clk;

  axis_hdr_insert_strip #(.DATA_WD(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_cmd    (valid_cmd),
    .ready_cmd    (ready_cmd),
    .cmd_mode     (cmd_mode),
    .data_insert  (data_insert),
    .cmd_byte_cnt (cmd_byte_cnt),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .keep_in      (keep_in),
    .last_in      (last_in),
    .ready_in     (ready_in),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .keep_out     (keep_out),
    .last_out     (last_out),
    .ready_out    (ready_out)
  );

  // ready_out driver: always 1, the fixed 1,0,0,1,0,1 pattern, or random
  initial begin
    int ph;
    ph = 0;
    ready_out = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: ready_out = 1'b1;
        1: begin ready_out = ((ph % 6) == 0) || ((ph % 6) == 3) || ((ph % 6) == 5); ph++; end
        default: ready_out = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Output monitor: collects taken beats and checks hold-stability on stalls
  initial begin
    logic [31:0] pd;
    logic [3:0]  pk;
    logic        pl;
    bit          pstall;
    pstall = 1'b0; pd = 32'h0; pk = 4'h0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_stable && pstall && rst_n) begin
        n_total++;
        if (valid_out !== 1'b1 || data_out !== pd || keep_out !== pk || last_out !== pl)
          $display("FAIL stall_hold got v%b %h/%b/%b want v1 %h/%b/%b", valid_out, data_out, keep_out, last_out, pd, pk, pl);
        else n_pass++;
      end
      pstall = rst_n && valid_out && !ready_out;
      pd = data_out; pk = keep_out; pl = last_out;
      if (rst_n && valid_out && ready_out) begin
        got_d.push_back(data_out); got_k.push_back(keep_out); got_l.push_back(last_out);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic m, input logic [2:0] c, input logic [31:0] h);
    bit took;
    int t;
    valid_cmd = 1'b1; cmd_mode = m; cmd_byte_cnt = c; data_insert = h;
    took = 1'b0; t = 0;
    while (!took && t < 300) begin
      @(negedge clk); took = ready_cmd; @(posedge clk); #1; t++;
    end
    valid_cmd = 1'b0; data_insert = 32'h0; cmd_byte_cnt = 3'd0;
    if (!took) begin n_total++; $display("FAIL cmd_timeout got no ready_cmd want handshake"); end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, output int waits);
    bit took;
    int ng;
    ng = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (ng) begin @(posedge clk); #1; end
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    took = 1'b0; waits = 0;
    while (!took && waits < 300) begin
      @(negedge clk); took = ready_in; @(posedge clk); #1;
      if (!took) waits++;
    end
    valid_in = 1'b0; data_in = 32'h0; keep_in = 4'h0; last_in = 1'b0;
    if (!took) begin n_total++; $display("FAIL beat_timeout got no ready_in want handshake"); end
  endtask

  // Reference model: byte stream = header bytes + payload bytes minus stripped prefix, chopped into beats
  task automatic build_expected(input logic m, input int cnt, input logic [31:0] hdr);
    logic [7:0]  bq[$];
    logic [31:0] d;
    logic [3:0]  kk;
    int c, s, k;
    exp_d.delete(); exp_k.delete(); exp_l.delete();
    s = 0;
    if (m == 1'b0) begin
      c = (cnt > NB) ? NB : cnt;
      for (int i = c - 1; i >= 0; i--) bq.push_back(hdr[i*8 +: 8]);
    end else begin
      s = (cnt >= NB) ? NB - 1 : cnt;
    end
    for (int b = 0; b < pay_d.size(); b++) begin
      k = $countones(pay_k[b]);
      for (int j = 0; j < k; j++) begin
        if (s > 0) s--;
        else bq.push_back(pay_d[b][31 - 8*j -: 8]);
      end
    end
    if (bq.size() == 0) begin
      exp_d.push_back(32'h0); exp_k.push_back(4'h0); exp_l.push_back(1'b1);
    end
    while (bq.size() > 0) begin
      d = 32'h0; kk = 4'h0;
      for (int j = 0; j < NB && bq.size() > 0; j++) begin
        d[31 - 8*j -: 8] = bq.pop_front();
        kk[NB - 1 - j] = 1'b1;
      end
      exp_d.push_back(d); exp_k.push_back(kk); exp_l.push_back(bq.size() == 0);
    end
  endtask

  task automatic run_packet(input string name, input logic m, input logic [2:0] c, input logic [31:0] h);
    int w, t;
    got_d.delete(); got_k.delete(); got_l.delete();
    send_cmd(m, c, h);
    for (int b = 0; b < pay_d.size(); b++) begin
      send_beat(pay_d[b], pay_k[b], (b == pay_d.size() - 1), w);
      stall_total += w;
    end
    t = 0;
    while (got_d.size() < exp_d.size() && t < 400) begin @(posedge clk); #1; t++; end
    repeat (4) begin @(posedge clk); #1; end
    n_total++;
    if (got_d.size() != exp_d.size())
      $display("FAIL %s beat_count got %0d want %0d", name, got_d.size(), exp_d.size());
    else n_pass++;
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_total++;
      if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] || got_l[i] !== exp_l[i])
        $display("FAIL %s beat%0d got %h/%b/%b want %h/%b/%b", name, i, got_d[i], got_k[i], got_l[i], exp_d[i], exp_k[i], exp_l[i]);
      else n_pass++;
    end
  endtask

  task automatic load_scn1();
    pay_d = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    pay_k = '{4'hF, 4'hF, 4'hF};
    exp_d = '{32'hAABB1122, 32'h33445566, 32'h778899AA, 32'hBBCC0000};
    exp_k = '{4'hF, 4'hF, 4'hF, 4'hC};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (ready_cmd !== 1'b1 || ready_in !== 1'b0)
      $display("FAIL reset_ready got cmd%b in%b want cmd1 in0", ready_cmd, ready_in);
    else n_pass++;
    n_total++;
    if (valid_out !== 1'b0 || data_out !== 32'h0 || keep_out !== 4'h0 || last_out !== 1'b0)
      $display("FAIL reset_out got v%b %h/%b/%b want v0 0/0/0", valid_out, data_out, keep_out, last_out);
    else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (ready_cmd !== 1'b1 || valid_out !== 1'b0)
      $display("FAIL reset_release got cmd%b v%b want cmd1 v0", ready_cmd, valid_out);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_insert();
    rdy_mode = 0; gap_max = 0;
    load_scn1();
    run_packet("ins2", 1'b0, 3'd2, 32'h0000AABB);
    pay_d = '{32'h12345678}; pay_k = '{4'hE};
    exp_d = '{32'hDEADBEEF, 32'h12345600}; exp_k = '{4'hF, 4'hE}; exp_l = '{1'b0, 1'b1};
    run_packet("ins4", 1'b0, 3'd4, 32'hDEADBEEF);
  endtask

  task automatic test_strip();
    rdy_mode = 0; gap_max = 0;
    pay_d = '{32'h11223344, 32'h55660000}; pay_k = '{4'hF, 4'hC};
    exp_d = '{32'h22334455, 32'h66000000}; exp_k = '{4'hF, 4'h8}; exp_l = '{1'b0, 1'b1};
    run_packet("strip1", 1'b1, 3'd1, 32'h0);
    pay_d = '{32'h11223344, 32'h55000000}; pay_k = '{4'hF, 4'h8};
    exp_d = '{32'h44550000}; exp_k = '{4'hC}; exp_l = '{1'b1};
    run_packet("strip3_merge", 1'b1, 3'd3, 32'h0);
    pay_d = '{32'h11000000}; pay_k = '{4'h8};
    exp_d = '{32'h00000000}; exp_k = '{4'h0}; exp_l = '{1'b1};
    run_packet("strip3_empty", 1'b1, 3'd3, 32'h0);
  endtask

  task automatic test_backpressure();
    rdy_mode = 1; gap_max = 2; chk_stable = 1'b1;
    load_scn1();
    run_packet("ins2_bp", 1'b0, 3'd2, 32'h0000AABB);
    rdy_mode = 0; gap_max = 0;
  endtask

  task automatic test_back_to_back();
    rdy_mode = 0; gap_max = 0; stall_total = 0;
    pay_d.delete(); pay_k.delete();
    for (int b = 0; b < 4; b++) begin pay_d.push_back($urandom); pay_k.push_back(4'hF); end
    build_expected(1'b0, 0, 32'h0);
    run_packet("b2b_pass", 1'b0, 3'd0, 32'h0);
    build_expected(1'b1, 2, 32'h0);
    run_packet("b2b_strip", 1'b1, 3'd2, 32'h0);
    n_total++;
    if (stall_total != 0) $display("FAIL b2b_throughput got %0d stall cycles want 0", stall_total);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w;
    rdy_mode = 0; gap_max = 0; chk_stable = 1'b0;
    send_cmd(1'b0, 3'd2, 32'h0000AABB);
    send_beat(32'h11223344, 4'hF, 1'b0, w);
    valid_in = 1'b1; data_in = 32'h55667788; keep_in = 4'hF; last_in = 1'b0;
    #3; rst_n = 1'b0; #1;
    n_total++;
    if (valid_out !== 1'b0 || data_out !== 32'h0 || keep_out !== 4'h0 || last_out !== 1'b0 || ready_in !== 1'b0)
      $display("FAIL midrst_out got v%b %h/%b/%b rin%b want all 0", valid_out, data_out, keep_out, last_out, ready_in);
    else n_pass++;
    valid_in = 1'b0; data_in = 32'h0; keep_in = 4'h0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (ready_cmd !== 1'b1 || valid_out !== 1'b0)
      $display("FAIL midrst_release got cmd%b v%b want cmd1 v0", ready_cmd, valid_out);
    else n_pass++;
    @(posedge clk); #1;
    pay_d = '{$urandom, $urandom, $urandom}; pay_k = '{4'hF, 4'hF, 4'hE};
    build_expected(1'b0, 0, 32'h0);
    run_packet("midrst_pass", 1'b0, 3'd0, 32'h12345678);
  endtask

  task automatic test_random();
    int nb, lk, cnt;
    logic m;
    logic [31:0] h;
    rdy_mode = 2; gap_max = 2; chk_stable = 1'b1;
    for (int p = 0; p < 25; p++) begin
      m = 1'($urandom_range(0, 1));
      cnt = int'($urandom_range(0, 7));
      h = $urandom;
      nb = int'($urandom_range(1, 5));
      lk = int'($urandom_range(1, 4));
      pay_d.delete(); pay_k.delete();
      for (int b = 0; b < nb; b++) begin
        pay_d.push_back($urandom);
        pay_k.push_back((b == nb - 1) ? 4'(4'hF << (4 - lk)) : 4'hF);
      end
      build_expected(m, cnt, h);
      run_packet($sformatf("rand%0d", p), m, 3'(cnt), h);
    end
    rdy_mode = 0; gap_max = 0; chk_stable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_insert();
    test_strip();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
